// File: rtl/sdram_arbit.sv
// sdram_arbit - command arbiter of the SDRAM interface.
// Grants the SDRAM to one of the init / auto-refresh / write / read sub-blocks
// at a time (fixed priority refresh > write > read), returns the start
// handshake to the winner and muxes the winner's command, bank and address
// onto the SDRAM pins.
// Ports:
//   i_sysclk, i_sysrst_n          clock, asynchronous active-low reset
//   i_init_*                      init sub-block: done level and command bus
//   i_refresh_*/i_write_*/i_read_* request level, done pulse, command bus
//   i_write_data/_en              write data and its valid
//   o_*_start                     grant, high for the whole granted state
//   o_sdram_*                     SDRAM pins (cke, command, bank, addr, DQ drive)
//   o_arbit_error                 sticky timeout flag
module sdram_arbit #(
  parameter logic [9:0] TIMEOUT_MAX = 10'd1023,
  parameter logic [3:0] NOP_CMD     = 4'b0111
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst_n,
  input  logic        i_init_done,
  input  logic [3:0]  i_init_cmd,
  input  logic [1:0]  i_init_ba,
  input  logic [12:0] i_init_addr,
  input  logic        i_refresh_request,
  input  logic [3:0]  i_refresh_cmd,
  input  logic [1:0]  i_refresh_ba,
  input  logic [12:0] i_refresh_addr,
  input  logic        i_refresh_done,
  input  logic        i_write_request,
  input  logic        i_write_done,
  input  logic [3:0]  i_write_cmd,
  input  logic [1:0]  i_write_ba,
  input  logic [12:0] i_write_addr,
  input  logic [15:0] i_write_data,
  input  logic        i_write_data_en,
  input  logic        i_read_request,
  input  logic        i_read_done,
  input  logic [3:0]  i_read_cmd,
  input  logic [1:0]  i_read_ba,
  input  logic [12:0] i_read_addr,
  output logic        o_refresh_start,
  output logic        o_write_start,
  output logic        o_read_start,
  output logic        o_sdram_cke,
  output logic        o_sdram_cs_n,
  output logic        o_sdram_ras_n,
  output logic        o_sdram_cas_n,
  output logic        o_sdram_we_n,
  output logic [1:0]  o_sdram_ba,
  output logic [12:0] o_sdram_addr,
  output logic        o_sdram_dq_oe,
  output logic [15:0] o_sdram_dq_out,
  output logic        o_arbit_error
);

  localparam logic [2:0] INIT  = 3'd0;
  localparam logic [2:0] ARBIT = 3'd1;
  localparam logic [2:0] AREF  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] READ  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       op_done;
  logic       timeout;

  // Only the done pulse of the currently granted block counts.
  assign op_done = ((state_q == AREF)  & i_refresh_done) |
                   ((state_q == WRITE) & i_write_done)   |
                   ((state_q == READ)  & i_read_done);
  assign timeout = (cnt_q == TIMEOUT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    case (state_q)
      INIT: begin
        if (i_init_done) state_d = ARBIT;
      end
      ARBIT: begin
        if (i_refresh_request)    state_d = AREF;
        else if (i_write_request) state_d = WRITE;
        else if (i_read_request)  state_d = READ;
      end
      AREF, WRITE, READ: begin
        if (timeout) err_d = 1'b1;
        if (op_done || timeout) state_d = ARBIT;
        else                    cnt_d   = cnt_q + 10'd1;
      end
      default: state_d = ARBIT;
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign o_refresh_start = (state_q == AREF);
  assign o_write_start   = (state_q == WRITE);
  assign o_read_start    = (state_q == READ);
  assign o_arbit_error   = err_q;

  // Reset feeds the pin mux directly so the bus shows NOP while reset is held.
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;

  always_comb begin
    cmd  = NOP_CMD;
    ba   = 2'b11;
    addr = 13'h1fff;
    if (i_sysrst_n) begin
      case (state_q)
        INIT: begin
          cmd  = i_init_cmd;
          ba   = i_init_ba;
          addr = i_init_addr;
        end
        AREF: begin
          cmd  = i_refresh_cmd;
          ba   = i_refresh_ba;
          addr = i_refresh_addr;
        end
        WRITE: begin
          cmd  = i_write_cmd;
          ba   = i_write_ba;
          addr = i_write_addr;
        end
        READ: begin
          cmd  = i_read_cmd;
          ba   = i_read_ba;
          addr = i_read_addr;
        end
        default: ;
      endcase
    end
  end

  assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = cmd;
  assign o_sdram_ba     = ba;
  assign o_sdram_addr   = addr;
  assign o_sdram_cke    = i_sysrst_n;
  assign o_sdram_dq_oe  = (state_q == WRITE) & i_write_data_en;
  assign o_sdram_dq_out = o_sdram_dq_oe ? i_write_data : 16'h0000;

endmodule
